// File: rtl/traffic_button_arbiter_if.sv
// Request/acknowledge bundle between the button front end and the light controller side.
interface traffic_button_arbiter_if;
    logic raw_a;
    logic raw_b;
    logic green_a;
    logic green_b;
    logic button_a;
    logic button_b;
    logic pending_a;
    logic pending_b;

    // Environment side: drives buttons and greens, observes requests
    modport master (
        output raw_a, raw_b, green_a, green_b,
        input  button_a, button_b, pending_a, pending_b
    );

    // Arbiter side
    modport slave (
        input  raw_a, raw_b, green_a, green_b,
        output button_a, button_b, pending_a, pending_b
    );
endinterface

// File: rtl/traffic_button_arbiter.sv
// Synchronises and debounces two request buttons, latches presses as pending
// requests and presents one request at a time to the traffic-light controller.
// Channel index 0 is side A, index 1 is side B.
module traffic_button_arbiter #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    traffic_button_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_e;

    logic [1:0]            raw_c;
    logic [1:0]            green_c;
    logic [1:0]            press_c;

    logic [1:0]            s1_q, s1_d;
    logic [1:0]            s2_q, s2_d;
    logic [1:0]            db_q, db_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            pend_q, pend_d;
    logic [1:0]            button_q, button_d;
    state_e                state_q, state_d;
    logic                  last_a_q, last_a_d;   // 1: A served last, 0: B served last

    assign raw_c   = {bus.raw_b, bus.raw_a};
    assign green_c = {bus.green_b, bus.green_a};

    // Synchronise, debounce, detect presses and maintain pending flags
    always_comb begin
        s1_d  = raw_c;
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        press_c = db_d & ~db_q;
        // A press on the same edge as the service acknowledge stays queued
        pend_d  = press_c | (pend_q & ~green_c);
    end

    // Arbiter next state: alternate priority on ties, hold grant until green
    always_comb begin
        state_d  = state_q;
        last_a_d = last_a_q;
        case (state_q)
            IDLE: begin
                if (pend_q[0] && (!pend_q[1] || !last_a_q)) begin
                    state_d = GRANT_A;
                end else if (pend_q[1]) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (green_c[0]) begin
                    state_d  = IDLE;
                    last_a_d = 1'b1;
                end
            end
            GRANT_B: begin
                if (green_c[1]) begin
                    state_d  = IDLE;
                    last_a_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        button_d = {state_d == GRANT_B, state_d == GRANT_A};
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            button_q <= '0;
            state_q  <= IDLE;
            last_a_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            button_q <= button_d;
            state_q  <= state_d;
            last_a_q <= last_a_d;
        end
    end

    assign bus.button_a  = button_q[0];
    assign bus.button_b  = button_q[1];
    assign bus.pending_a = pend_q[0];
    assign bus.pending_b = pend_q[1];

endmodule

// File: tb/tb_traffic_button_arbiter.sv
// Directed bench for traffic_button_arbiter with DEBOUNCE=4.
// Observed vector order: {button_a, button_b, pending_a, pending_b}.
module tb_traffic_button_arbiter;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [3:0] obs;

    traffic_button_arbiter_if bus ();

    traffic_button_arbiter #(.DEBOUNCE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign obs = {bus.button_a, bus.button_b, bus.pending_a, bus.pending_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_immediate: got %b expected 0000", obs);
        end
        tick(2);
        #2 reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b expected 0000", i, obs);
            end
        end
    endtask

    task automatic test_single_press();
        logic [3:0] exp;
        bus.raw_a = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            bus.green_a = (i == 10);
            tick(1);
            if (i < 6)       exp = 4'b0000;
            else if (i == 6) exp = 4'b0010;
            else if (i < 10) exp = 4'b1010;
            else             exp = 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_press cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        bus.green_a = 1'b0;
        bus.raw_a   = 1'b0;
        tick(8);
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL single_release: got %b expected 0000", obs);
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        for (int i = 1; i <= 13; i++) begin
            bus.raw_b = (i <= 3);
            tick(1);
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL glitch_3 cycle %0d: got %b expected 0000", i, obs);
            end
        end
        for (int i = 1; i <= 8; i++) begin
            bus.raw_b   = (i <= 4);
            bus.green_b = (i == 8);
            tick(1);
            if (i < 6)       exp = 4'b0000;
            else if (i == 6) exp = 4'b0001;
            else if (i == 7) exp = 4'b0101;
            else             exp = 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pulse_4 cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        bus.green_b = 1'b0;
        tick(8);
    endtask

    task automatic test_tie();
        bus.raw_a = 1'b1;
        bus.raw_b = 1'b1;
        tick(6);
        checks++;
        if (obs !== 4'b0011) begin
            errors++;
            $display("FAIL tie1_pending: got %b expected 0011", obs);
        end
        tick(1);
        checks++;
        if (obs !== 4'b1011) begin
            errors++;
            $display("FAIL tie1_grant_a: got %b expected 1011", obs);
        end
        bus.green_a = 1'b1;
        tick(1);
        bus.green_a = 1'b0;
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL tie1_idle: got %b expected 0001", obs);
        end
        tick(1);
        checks++;
        if (obs !== 4'b0101) begin
            errors++;
            $display("FAIL tie1_grant_b: got %b expected 0101", obs);
        end
        bus.green_b = 1'b1;
        tick(1);
        bus.green_b = 1'b0;
        bus.raw_a   = 1'b0;
        bus.raw_b   = 1'b0;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL tie1_done: got %b expected 0000", obs);
        end
        tick(8);
        // Lone A service so that A becomes the last served side
        bus.raw_a = 1'b1;
        tick(7);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL lone_a_grant: got %b expected 1010", obs);
        end
        bus.green_a = 1'b1;
        tick(1);
        bus.green_a = 1'b0;
        bus.raw_a   = 1'b0;
        tick(8);
        bus.raw_a = 1'b1;
        bus.raw_b = 1'b1;
        tick(7);
        checks++;
        if (obs !== 4'b0111) begin
            errors++;
            $display("FAIL tie2_grant_b: got %b expected 0111", obs);
        end
        bus.green_b = 1'b1;
        tick(1);
        bus.green_b = 1'b0;
        checks++;
        if (obs !== 4'b0010) begin
            errors++;
            $display("FAIL tie2_idle: got %b expected 0010", obs);
        end
        tick(1);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL tie2_grant_a: got %b expected 1010", obs);
        end
        bus.green_a = 1'b1;
        tick(1);
        bus.green_a = 1'b0;
        bus.raw_a   = 1'b0;
        bus.raw_b   = 1'b0;
        tick(8);
    endtask

    task automatic test_press_during_service();
        bus.raw_a = 1'b1;
        tick(7);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL svc_first_grant: got %b expected 1010", obs);
        end
        bus.raw_a = 1'b0;
        tick(8);
        bus.raw_a = 1'b1;
        tick(5);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL svc_held: got %b expected 1010", obs);
        end
        // Debounced re-press lands on the edge that samples green_a
        bus.green_a = 1'b1;
        tick(1);
        bus.green_a = 1'b0;
        checks++;
        if (obs !== 4'b0010) begin
            errors++;
            $display("FAIL svc_coincide: got %b expected 0010", obs);
        end
        tick(1);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL svc_regrant: got %b expected 1010", obs);
        end
        bus.green_a = 1'b1;
        tick(1);
        bus.green_a = 1'b0;
        bus.raw_a   = 1'b0;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL svc_done: got %b expected 0000", obs);
        end
        tick(8);
    endtask

    task automatic test_reset_mid_grant();
        bus.raw_a = 1'b1;
        bus.raw_b = 1'b1;
        tick(7);
        checks++;
        if (obs !== 4'b0111) begin
            errors++;
            $display("FAIL midrst_grant_b: got %b expected 0111", obs);
        end
        bus.raw_a = 1'b0;
        bus.raw_b = 1'b0;
        tick(1);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_immediate: got %b expected 0000", obs);
        end
        tick(2);
        #2 reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL midrst_after cycle %0d: got %b expected 0000", i, obs);
            end
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        bus.raw_a   = 1'b0;
        bus.raw_b   = 1'b0;
        bus.green_a = 1'b0;
        bus.green_b = 1'b0;
        tick(2);
        test_reset();
        test_single_press();
        test_glitch();
        test_tie();
        test_press_during_service();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
